control_fb_writer: RTL and testbench

- Downstream of the row-read command stage.
- Consumes its per-byte write stream (row/column/pixel/data, toggle-style access start, done pulse) and buffers writes in a small FIFO.
- Drains the FIFO into a single-port framebuffer RAM through a req/grant handshake shared with the display scan-out reader.
- Optionally double-buffers the framebuffer, swapping banks after a completed row command once all its writes have landed.

---
 rtl/control_fb_writer_pkg.sv | 57 +++++
 rtl/sync_fifo_small.sv | 41 ++++
 rtl/control_fb_writer.sv | 142 ++++++++++++++
 tb/tb_control_fb_writer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_fb_writer_pkg.sv
// Shared packages for the framebuffer writer: frame geometry, width helpers,
// and writer types. The double-buffer option is selected by FB_DOUBLE_BUFFER_EN.
package params_pkg;
    localparam int unsigned BYTES_PER_PIXEL = 4;
    localparam int unsigned PIXEL_HEIGHT    = 8;
    localparam int unsigned PIXEL_WIDTH     = 8;
endpackage

package calc_pkg;
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    function automatic int unsigned num_row_address_bits(input int unsigned height);
        return clog2_min1(height);
    endfunction

    function automatic int unsigned num_column_address_bits(input int unsigned width);
        return clog2_min1(width);
    endfunction

    function automatic int unsigned num_pixelcolorselect_bits(input int unsigned bpp);
        return clog2_min1(bpp);
    endfunction

    // One bank holds height*width*bpp bytes; a second bank doubles the span.
    function automatic int unsigned fb_addr_bits(input int unsigned height,
                                                 input int unsigned width,
                                                 input int unsigned bpp,
                                                 input bit          double_buf);
        return clog2_min1(height * width * bpp * (double_buf ? 2 : 1));
    endfunction
endpackage

package fb_writer_pkg;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit FB_DOUBLE_BUF = 1'b1;
`else
    localparam bit FB_DOUBLE_BUF = 1'b0;
`endif

    localparam int unsigned FB_ADDR_W = calc_pkg::fb_addr_bits(params_pkg::PIXEL_HEIGHT,
                                                               params_pkg::PIXEL_WIDTH,
                                                               params_pkg::BYTES_PER_PIXEL,
                                                               FB_DOUBLE_BUF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WRITE
    } fb_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } fb_write_entry_t;
endpackage

// File: rtl/sync_fifo_small.sv
// Small synchronous FIFO with registered storage and a combinational head.
// Pointers carry one wrap bit so full and empty are distinguishable.
module sync_fifo_small #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign head  = mem[rd_ptr[PW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
endmodule

// File: rtl/control_fb_writer.sv
// Buffers upstream byte writes and drains them into the shared framebuffer RAM
// over a req/grant port. FB_DOUBLE_BUFFER_EN adds bank swapping after each row.
module control_fb_writer #(
    parameter int unsigned BYTES_PER_PIXEL = params_pkg::BYTES_PER_PIXEL,
    parameter int unsigned PIXEL_HEIGHT    = params_pkg::PIXEL_HEIGHT,
    parameter int unsigned PIXEL_WIDTH     = params_pkg::PIXEL_WIDTH,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic [calc_pkg::num_row_address_bits(PIXEL_HEIGHT)-1:0]         row,
    input  logic [calc_pkg::num_column_address_bits(PIXEL_WIDTH)-1:0]       column,
    input  logic [calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)-1:0] pixel,
    input  logic [7:0] data_in,
    input  logic       ram_write_enable,
    input  logic       ram_access_start,
    input  logic       done,
    output logic       mem_req,
    input  logic       mem_grant,
    output logic [calc_pkg::fb_addr_bits(PIXEL_HEIGHT, PIXEL_WIDTH, BYTES_PER_PIXEL,
                                         fb_writer_pkg::FB_DOUBLE_BUF)-1:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       mem_we,
    output logic       write_bank,
    output logic       display_bank,
    output logic       frame_swapped,
    output logic       busy,
    output logic       overflow
);
    import fb_writer_pkg::*;

    localparam int unsigned AW = calc_pkg::fb_addr_bits(PIXEL_HEIGHT, PIXEL_WIDTH,
                                                        BYTES_PER_PIXEL, FB_DOUBLE_BUF);
    localparam int unsigned FRAME_BYTES = PIXEL_HEIGHT * PIXEL_WIDTH * BYTES_PER_PIXEL;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fb_state_e       state, state_next;
    logic            prev_as;
    logic            write_event;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [AW-1:0]   enq_addr;
    fb_write_entry_t enq_entry, head_entry;
    logic            swap_pending;
    logic            swap_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_as <= 1'b0;
        else        prev_as <= ram_access_start;
    end

    assign write_event = (ram_access_start != prev_as) && ram_write_enable;
    assign fifo_pop    = (state == ST_WRITE);
    // A full queue still accepts when the head leaves in the same cycle.
    assign fifo_push   = write_event && (!fifo_full || fifo_pop);

    always_comb begin
        enq_addr = (AW'(row) * AW'(PIXEL_WIDTH) + AW'(column)) * AW'(BYTES_PER_PIXEL)
                   + AW'(pixel);
`ifdef FB_DOUBLE_BUFFER_EN
        if (write_bank) enq_addr = enq_addr + AW'(FRAME_BYTES);
`endif
        enq_entry.addr = enq_addr;
        enq_entry.data = data_in;
    end

    sync_fifo_small #(
        .WIDTH ($bits(fb_write_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_write_queue (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (enq_entry),
        .head  (head_entry),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_next = ST_REQ;
            end
            ST_REQ: begin
                mem_req  = 1'b1;
                mem_addr = head_entry.addr;
                mem_data = head_entry.data;
                if (mem_grant) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = head_entry.addr;
                mem_data = head_entry.data;
                state_next = ((fifo_count > CW'(1)) || fifo_push) ? ST_REQ : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Swap only once every write of the committed row has reached the RAM.
    assign swap_fire = swap_pending && fifo_empty && (state == ST_IDLE) && !fifo_push;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swap_pending  <= 1'b0;
            frame_swapped <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            frame_swapped <= swap_fire;
            if (done)           swap_pending <= 1'b1;
            else if (swap_fire) swap_pending <= 1'b0;
            if (write_event && fifo_full && !fifo_pop) overflow <= 1'b1;
        end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         write_bank <= 1'b0;
        else if (swap_fire) write_bank <= ~write_bank;
    end
    assign display_bank = ~write_bank;
`else
    assign write_bank   = 1'b0;
    assign display_bank = 1'b0;
`endif

    assign busy = !fifo_empty || (state != ST_IDLE) || swap_pending;
endmodule

// File: tb/tb_control_fb_writer.sv
// Self-checking bench for control_fb_writer: directed vector table, multi-cycle
// corner sequences, and a randomized stream scored against a queue model.
module tb_control_fb_writer;
    localparam int unsigned BPP   = params_pkg::BYTES_PER_PIXEL;
    localparam int unsigned H     = params_pkg::PIXEL_HEIGHT;
    localparam int unsigned W     = params_pkg::PIXEL_WIDTH;
    localparam int unsigned FRAME = H * W * BPP;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam int unsigned RW = calc_pkg::num_row_address_bits(H);
    localparam int unsigned CLW = calc_pkg::num_column_address_bits(W);
    localparam int unsigned PXW = calc_pkg::num_pixelcolorselect_bits(BPP);
    localparam int unsigned AW = calc_pkg::fb_addr_bits(H, W, BPP, DB);

    logic clk, reset;
    logic [RW-1:0]  row;
    logic [CLW-1:0] column;
    logic [PXW-1:0] pixel;
    logic [7:0]     data_in;
    logic ram_write_enable, ram_access_start, done;
    logic mem_req, mem_grant, mem_we;
    logic [AW-1:0]  mem_addr;
    logic [7:0]     mem_data;
    logic write_bank, display_bank, frame_swapped, busy, overflow;

    control_fb_writer #(
        .BYTES_PER_PIXEL (BPP),
        .PIXEL_HEIGHT    (H),
        .PIXEL_WIDTH     (W),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .row              (row),
        .column           (column),
        .pixel            (pixel),
        .data_in          (data_in),
        .ram_write_enable (ram_write_enable),
        .ram_access_start (ram_access_start),
        .done             (done),
        .mem_req          (mem_req),
        .mem_grant        (mem_grant),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .mem_we           (mem_we),
        .write_bank       (write_bank),
        .display_bank     (display_bank),
        .frame_swapped    (frame_swapped),
        .busy             (busy),
        .overflow         (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t obs[$];
    wr_t exp_q[$];
    int  swaps   = 0;
    int  swap_at = -1;
    int  checks  = 0;
    int  passed  = 0;
    bit  xb      = 1'b0;

    always @(posedge clk) begin
        if (reset && mem_we) obs.push_back('{mem_addr, mem_data});
        if (reset && frame_swapped) begin
            swaps   = swaps + 1;
            swap_at = obs.size();
        end
    end

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    endtask

    function automatic logic [AW-1:0] eaddr(input int unsigned bank, input int unsigned r,
                                            input int unsigned c, input int unsigned p);
        int unsigned a;
        a = bank * FRAME + (r * W + c) * BPP + p;
        return a[AW-1:0];
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ev(input int unsigned r, input int unsigned c, input int unsigned p,
                      input logic [7:0] d, input bit we, input bit dn);
        row              = RW'(r);
        column           = CLW'(c);
        pixel            = PXW'(p);
        data_in          = d;
        ram_write_enable = we;
        done             = dn;
        ram_access_start = ~ram_access_start;
        cyc(1);
        ram_write_enable = 1'b0;
        done             = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        cyc(1);
        done = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, input string nm);
        int k = 0;
        while (obs.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk(nm, obs.size(), n);
    endtask

    task automatic wait_swap(input int n, input int budget, input string nm);
        int k = 0;
        while (swaps < n && k < budget) begin
            cyc(1);
            k++;
        end
        chk(nm, swaps, n);
    endtask

    task automatic chk_banks(input string nm);
        chk({nm, "_write_bank"},   write_bank,   DB ? xb : 1'b0);
        chk({nm, "_display_bank"}, display_bank, DB ? ~xb : 1'b0);
    endtask

    typedef struct {
        int unsigned   r, c, p;
        logic [7:0]    d;
        logic [AW-1:0] ea;
    } vec_t;

    vec_t vt[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        vt[0] = '{2, 3, 0, 8'hA1, AW'((2 * W + 3) * BPP + 0)};
        vt[1] = '{2, 3, 1, 8'hA2, AW'((2 * W + 3) * BPP + 1)};
        vt[2] = '{2, 3, 2, 8'hA3, AW'((2 * W + 3) * BPP + 2)};
        vt[3] = '{2, 3, 3, 8'hA4, AW'((2 * W + 3) * BPP + 3)};
        vt[4] = '{H - 1, W - 1, BPP - 1, 8'hFF, AW'(FRAME - 1)};
        vt[5] = '{0, 0, 0, 8'h00, AW'(0)};

        reset = 1'b0; row = '0; column = '0; pixel = '0; data_in = '0;
        ram_write_enable = 1'b0; ram_access_start = 1'b0; done = 1'b0; mem_grant = 1'b1;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_swapped", frame_swapped, 0);
        chk_banks("rst");
        cyc(2);
        reset = 1'b1;
        cyc(2);

        // Directed vectors, exact latency: entry, then REQ, then the write strobe.
        for (int i = 0; i < 6; i++) begin
            obs.delete();
            ev(vt[i].r, vt[i].c, vt[i].p, vt[i].d, 1'b1, 1'b0);
            chk("vec_req_lat0", mem_req, 0);
            chk("vec_busy", busy, 1);
            cyc(1);
            chk("vec_req_lat1", mem_req, 1);
            cyc(1);
            chk("vec_we", mem_we, 1);
            chk("vec_addr", mem_addr, vt[i].ea);
            chk("vec_data", mem_data, vt[i].d);
            cyc(2);
            chk("vec_idle_busy", busy, 0);
            chk("vec_write_count", obs.size(), 1);
        end
        chk("vec_overflow", overflow, 0);

        // Toggle with write enable low is ignored.
        obs.delete();
        ev(1, 1, 1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("we0_mem_req", mem_req, 0);
            chk("we0_busy", busy, 0);
            cyc(1);
        end
        chk("we0_writes", obs.size(), 0);

        // Overflow: grant withheld, five events into a four-entry queue.
        obs.delete();
        mem_grant = 1'b0;
        for (int i = 0; i < 5; i++) ev(0, i, 0, 8'h10 + 8'(i), 1'b1, 1'b0);
        cyc(2);
        chk("ovf_mem_req", mem_req, 1);
        chk("ovf_mem_we", mem_we, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_no_writes", obs.size(), 0);
        mem_grant = 1'b1;
        wait_obs(4, 50, "ovf_drain");
        cyc(10);
        chk("ovf_exact4", obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            chk("ovf_data", obs[i].data, 8'h10 + 8'(i));
            chk("ovf_addr", obs[i].addr, eaddr(0, 0, i, 0));
        end
        chk("ovf_sticky", overflow, 1);

        // Asynchronous reset with entries queued.
        obs.delete();
        mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) ev(4, i, 1, 8'h30 + 8'(i), 1'b1, 1'b0);
        cyc(2);
        chk("ar_mem_req_pre", mem_req, 1);
        chk("ar_busy_pre", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_mem_req", mem_req, 0);
        chk("ar_mem_we", mem_we, 0);
        chk("ar_busy", busy, 0);
        chk("ar_overflow", overflow, 0);
        xb = 1'b0;
        cyc(2);
        reset = 1'b1;
        mem_grant = 1'b1;
        cyc(10);
        chk("ar_no_writes", obs.size(), 0);
        chk("ar_mem_req_post", mem_req, 0);
        chk_banks("ar");

        // Full row, done while entries are still queued; a second done is absorbed.
        obs.delete();
        s0 = swaps;
        for (int c = 0; c < W; c++)
            for (int p = 0; p < BPP; p++) begin
                if (c * BPP + p == W * BPP - 2) mem_grant = 1'b0;
                ev(1, c, p, 8'(c * BPP + p), 1'b1, 1'b0);
                cyc(1);
            end
        pulse_done();
        cyc(1);
        pulse_done();
        cyc(3);
        chk("row_busy_held", busy, 1);
        chk("row_no_early_swap", swaps, s0);
        mem_grant = 1'b1;
        wait_obs(W * BPP, 300, "row_drain");
        wait_swap(s0 + 1, 50, "row_swap");
        chk("row_swap_after_last", swap_at, W * BPP);
        cyc(5);
        chk("row_single_swap", swaps, s0 + 1);
        for (int i = 0; i < W * BPP && i < obs.size(); i++) begin
            chk("row_addr", obs[i].addr, eaddr(xb, 1, i / BPP, i % BPP));
            chk("row_data", obs[i].data, 8'(i));
        end
        if (DB) xb = ~xb;
        chk_banks("row");
        obs.delete();
        ev(0, 0, 1, 8'h5A, 1'b1, 1'b0);
        wait_obs(1, 20, "post_swap_drain");
        if (obs.size() > 0) chk("post_swap_addr", obs[0].addr, eaddr(xb, 0, 0, 1));

        // done coincident with the last write event.
        obs.delete();
        s0 = swaps;
        ev(3, 4, 2, 8'hC3, 1'b1, 1'b1);
        wait_obs(1, 20, "coinc_drain");
        if (obs.size() > 0) chk("coinc_addr", obs[0].addr, eaddr(xb, 3, 4, 2));
        wait_swap(s0 + 1, 30, "coinc_swap");
        chk("coinc_swap_after_write", swap_at, 1);
        if (DB) xb = ~xb;
        chk_banks("coinc");

        // Randomized stream against the queue model.
        obs.delete();
        exp_q.delete();
        for (int i = 0; i < 80; i++) begin
            int unsigned r, c, p;
            logic [7:0] d;
            bit we, dn;
            r  = $urandom_range(H - 1, 0);
            c  = $urandom_range(W - 1, 0);
            p  = $urandom_range(BPP - 1, 0);
            d  = 8'($urandom);
            we = ($urandom % 5) != 0;
            dn = ($urandom % 8) == 0;
            if (we) exp_q.push_back('{eaddr(xb, r, c, p), d});
            s0 = swaps;
            ev(r, c, p, d, we, dn);
            cyc(1);
            if (dn) begin
                wait_swap(s0 + 1, 40, "rand_swap");
                chk("rand_swap_order", swap_at, exp_q.size());
                if (DB) xb = ~xb;
            end
        end
        wait_obs(exp_q.size(), 200, "rand_drain");
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk("rand_addr", obs[i].addr, exp_q[i].addr);
            chk("rand_data", obs[i].data, exp_q[i].data);
        end
        chk("rand_overflow", overflow, 0);
        chk("rand_busy", busy, 0);
        chk_banks("rand");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
